// File: rtl/pipe_id_hazard_sb.sv
// pipe_id_hazard_sb
// Operand-hazard unit for the ID stage. A DEPTH-entry destination scoreboard
// follows each issued writer through the stages after ID (entry 0 = EXE,
// 1 = MEM, 2 = WB, ...). The unit picks the youngest in-flight producer for
// each source operand, stalls on load-use, inserts bubbles and counts stall
// cycles.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_ra1/id_ra2     source addresses; id_use1/id_use2 mark them as read
//   id_wen/id_wa      destination write enable and address
//   id_load           instruction is a load
//   flush             kill of the instruction in ID
//   rf_rd1/rf_rd2     regfile read data
//   stage_d           stage k result on bits [k*DW +: DW]
//   rd1_id/rd2_id     resolved operands
//   fwd1_sel/fwd2_sel 0 = regfile, k+1 = stage k
//   stall             hold PC and IF/ID, bubble into ID/EXE
//   issue             ID instruction advances this cycle
//   sb_valid          scoreboard valid bits (debug)
//   stall_cnt         saturating stall-cycle counter
module pipe_id_hazard_sb #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LD_STAGE = 1,
    localparam int unsigned SELW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [AW-1:0]       id_ra1,
    input  logic [AW-1:0]       id_ra2,
    input  logic                id_use1,
    input  logic                id_use2,
    input  logic                id_wen,
    input  logic [AW-1:0]       id_wa,
    input  logic                id_load,
    input  logic                flush,
    input  logic [DW-1:0]       rf_rd1,
    input  logic [DW-1:0]       rf_rd2,
    input  logic [DEPTH*DW-1:0] stage_d,
    output logic [DW-1:0]       rd1_id,
    output logic [DW-1:0]       rd2_id,
    output logic [SELW-1:0]     fwd1_sel,
    output logic [SELW-1:0]     fwd2_sel,
    output logic                stall,
    output logic                issue,
    output logic [DEPTH-1:0]    sb_valid,
    output logic [15:0]         stall_cnt
);

    logic [DEPTH-1:0] sb_v_q;
    logic [DEPTH-1:0] sb_ld_q;
    logic [AW-1:0]    sb_wa_q [DEPTH];
    logic [15:0]      stall_cnt_q;

    logic hit1, hit2;
    logic ld_haz1, ld_haz2;
    logic raw_stall;

    // Youngest match wins: scan from entry 0 and stop at the first hit.
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        ld_haz1  = 1'b0;
        ld_haz2  = 1'b0;
        fwd1_sel = '0;
        fwd2_sel = '0;
        rd1_id   = rf_rd1;
        rd2_id   = rf_rd2;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!hit1 && id_use1 && (id_ra1 != '0) && sb_v_q[k] && (sb_wa_q[k] == id_ra1)) begin
                hit1     = 1'b1;
                fwd1_sel = SELW'(k + 1);
                rd1_id   = stage_d[k*DW +: DW];
                // Load data is not available before stage LD_STAGE.
                ld_haz1  = sb_ld_q[k] && (k < LD_STAGE);
            end
            if (!hit2 && id_use2 && (id_ra2 != '0) && sb_v_q[k] && (sb_wa_q[k] == id_ra2)) begin
                hit2     = 1'b1;
                fwd2_sel = SELW'(k + 1);
                rd2_id   = stage_d[k*DW +: DW];
                ld_haz2  = sb_ld_q[k] && (k < LD_STAGE);
            end
        end
    end

    assign raw_stall = ld_haz1 | ld_haz2;
    // A flushed instruction never stalls.
    assign stall     = id_valid & ~flush & raw_stall;
    assign issue     = id_valid & ~flush & ~stall;
    assign sb_valid  = sb_v_q;
    assign stall_cnt = stall_cnt_q;

    // Scoreboard shifts every cycle; a stalled or killed slot enters as a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v_q  <= '0;
            sb_ld_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                sb_wa_q[k] <= '0;
            end
        end else begin
            sb_v_q     <= {sb_v_q[DEPTH-2:0], issue & id_wen & (id_wa != '0)};
            sb_ld_q    <= {sb_ld_q[DEPTH-2:0], issue & id_load};
            sb_wa_q[0] <= issue ? id_wa : '0;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                sb_wa_q[k] <= sb_wa_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_id_hazard_sb.sv
// Bench for pipe_id_hazard_sb (DEPTH=3, LD_STAGE=1, DW=32). The reference
// model keeps a history of what entered the pipe after ID each cycle; the
// entry k stages ahead is simply the record issued k+1 cycles ago.
module tb_pipe_id_hazard_sb;

    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int DEPTH    = 3;
    localparam int LD_STAGE = 1;
    localparam int SELW     = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                id_valid;
    logic [AW-1:0]       id_ra1, id_ra2, id_wa;
    logic                id_use1, id_use2, id_wen, id_load, flush;
    logic [DW-1:0]       rf_rd1, rf_rd2;
    logic [DEPTH*DW-1:0] stage_d;
    logic [DW-1:0]       rd1_id, rd2_id;
    logic [SELW-1:0]     fwd1_sel, fwd2_sel;
    logic                stall, issue;
    logic [DEPTH-1:0]    sb_valid;
    logic [15:0]         stall_cnt;

    pipe_id_hazard_sb #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .LD_STAGE(LD_STAGE)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
        .id_use1(id_use1), .id_use2(id_use2), .id_wen(id_wen), .id_wa(id_wa),
        .id_load(id_load), .flush(flush), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .stage_d(stage_d), .rd1_id(rd1_id), .rd2_id(rd2_id), .fwd1_sel(fwd1_sel),
        .fwd2_sel(fwd2_sel), .stall(stall), .issue(issue), .sb_valid(sb_valid),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit [AW-1:0] wa;
        bit          ld;
    } rec_t;

    rec_t hist [$];
    int   checks = 0;
    int   errors = 0;
    int   cnt    = 0;
    bit   m_stall, m_issue;
    int   c0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rec_t z;
        z.v = 1'b0; z.wa = '0; z.ld = 1'b0;
        hist.delete();
        for (int k = 0; k < DEPTH; k++) hist.push_back(z);
        cnt = 0;
    endtask

    function automatic void lookup(input logic [AW-1:0] ra, input logic en,
                                   output int sel, output bit ldh);
        sel = 0;
        ldh = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sel == 0 && en && ra != '0 && hist[k].v && hist[k].wa == ra) begin
                sel = k + 1;
                ldh = hist[k].ld && (k < LD_STAGE);
            end
        end
    endfunction

    task automatic rand_data();
        rf_rd1 = $urandom;
        rf_rd2 = $urandom;
        for (int k = 0; k < DEPTH; k++) stage_d[k*DW +: DW] = $urandom;
    endtask

    task automatic set_ins(input bit v, input logic [AW-1:0] ra1, input bit u1,
                           input logic [AW-1:0] ra2, input bit u2, input bit wen,
                           input logic [AW-1:0] wa, input bit ld, input bit fl);
        id_valid = v;   id_ra1 = ra1; id_use1 = u1; id_ra2 = ra2; id_use2 = u2;
        id_wen   = wen; id_wa  = wa;  id_load = ld; flush  = fl;
        rand_data();
    endtask

    // Settle, then compare every output against the model.
    task automatic eval();
        int s1, s2;
        bit h1, h2;
        logic [DW-1:0] e1, e2;
        logic [DEPTH-1:0] ev;
        #1;
        lookup(id_ra1, id_use1, s1, h1);
        lookup(id_ra2, id_use2, s2, h2);
        e1 = (s1 == 0) ? rf_rd1 : stage_d[(s1-1)*DW +: DW];
        e2 = (s2 == 0) ? rf_rd2 : stage_d[(s2-1)*DW +: DW];
        m_stall = id_valid && !flush && (h1 || h2);
        m_issue = id_valid && !flush && !m_stall;
        for (int k = 0; k < DEPTH; k++) ev[k] = hist[k].v;
        chk("fwd1_sel", 32'(fwd1_sel), 32'(s1));
        chk("fwd2_sel", 32'(fwd2_sel), 32'(s2));
        chk("rd1_id", rd1_id, e1);
        chk("rd2_id", rd2_id, e2);
        chk("stall", 32'(stall), 32'(m_stall));
        chk("issue", 32'(issue), 32'(m_issue));
        chk("sb_valid", 32'(sb_valid), 32'(ev));
        chk("stall_cnt", 32'(stall_cnt), (cnt > 65535) ? 32'd65535 : 32'(cnt));
    endtask

    task automatic tick();
        rec_t r;
        @(posedge clk);
        if (m_stall) cnt++;
        r.v  = m_issue && id_wen && (id_wa != '0);
        r.wa = m_issue ? id_wa : '0;
        r.ld = m_issue && id_load;
        hist.push_front(r);
        void'(hist.pop_back());
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state with no pending writers
        eval();
        chk("rst_sb_valid", 32'(sb_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();

        // 1: reset asserted mid-stall drops stall at once
        set_ins(1, 0, 0, 0, 0, 1, 7, 1, 0);
        eval(); tick();
        set_ins(1, 7, 1, 0, 0, 1, 8, 0, 0);
        rf_rd1 = 32'h11;
        eval();
        chk("t1_pre_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("t1_sb_valid", 32'(sb_valid), 32'd0);
        chk("t1_stall", 32'(stall), 32'd0);
        chk("t1_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("t1_fwd1_sel", 32'(fwd1_sel), 32'd0);
        chk("t1_rd1_id", rd1_id, 32'h11);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 2: ALU writer r5 seen at EXE, MEM, WB, then gone
        set_ins(1, 0, 0, 0, 0, 1, 5, 0, 0);
        eval(); tick();
        for (int k = 0; k <= DEPTH; k++) begin
            set_ins(1, 5, 1, 0, 0, 0, 0, 0, 0);
            eval();
            chk("t2_fwd1_sel", 32'(fwd1_sel), 32'(k == DEPTH ? 0 : k + 1));
            chk("t2_rd1_id", rd1_id, (k == DEPTH) ? rf_rd1 : stage_d[k*DW +: DW]);
            tick();
        end

        // 3: load-use stalls exactly one cycle, then forwards from MEM
        set_ins(1, 0, 0, 0, 0, 1, 7, 1, 0);
        eval(); tick();
        set_ins(1, 7, 1, 0, 0, 1, 8, 0, 0);
        eval();
        chk("t3_stall", 32'(stall), 32'd1);
        chk("t3_issue", 32'(issue), 32'd0);
        tick();
        rand_data();
        eval();
        chk("t3_stall_after", 32'(stall), 32'd0);
        chk("t3_fwd1_sel", 32'(fwd1_sel), 32'd2);
        chk("t3_rd1_id", rd1_id, stage_d[63:32]);
        chk("t3_sb_valid", 32'(sb_valid), 32'b010);
        chk("t3_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // 4: youngest of two r3 writers; r4 from WB on operand 2
        set_ins(1, 0, 0, 0, 0, 1, 4, 0, 0); eval(); tick();
        set_ins(1, 0, 0, 0, 0, 1, 3, 0, 0); eval(); tick();
        set_ins(1, 0, 0, 0, 0, 1, 3, 0, 0); eval(); tick();
        set_ins(1, 3, 1, 4, 1, 0, 0, 0, 0);
        eval();
        chk("t4_fwd1_sel", 32'(fwd1_sel), 32'd1);
        chk("t4_fwd2_sel", 32'(fwd2_sel), 32'd3);
        chk("t4_rd2_id", rd2_id, stage_d[95:64]);
        tick();
        set_ins(1, 3, 1, 3, 1, 0, 0, 0, 0);
        eval();
        chk("t4_same_sel1", 32'(fwd1_sel), 32'd2);
        chk("t4_same_sel2", 32'(fwd2_sel), 32'd2);
        tick();

        // 5: writes to r0 are never tracked
        set_ins(1, 0, 0, 0, 0, 1, 0, 0, 0); eval(); tick();
        set_ins(1, 0, 1, 0, 0, 0, 0, 0, 0);
        rf_rd1 = 32'h0;
        eval();
        chk("t5_fwd1_sel", 32'(fwd1_sel), 32'd0);
        chk("t5_stall", 32'(stall), 32'd0);
        chk("t5_entry0_v", 32'(sb_valid[0]), 32'd0);
        chk("t5_rd1_id", rd1_id, 32'd0);
        tick();

        // 6: flush beats a load-use hazard
        set_ins(1, 0, 0, 0, 0, 1, 9, 1, 0); eval(); tick();
        set_ins(1, 9, 1, 0, 0, 1, 10, 0, 1);
        c0 = cnt;
        eval();
        chk("t6_stall", 32'(stall), 32'd0);
        chk("t6_issue", 32'(issue), 32'd0);
        tick();
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval();
        chk("t6_bubble", 32'(sb_valid[0]), 32'd0);
        chk("t6_stall_cnt", 32'(stall_cnt), 32'(c0));
        tick();

        // Random traffic; a stalled instruction is held in ID
        for (int i = 0; i < 600; i++) begin
            if (m_stall) begin
                rand_data();
                flush = ($urandom_range(0, 9) == 0);
            end else begin
                set_ins($urandom_range(0, 9) < 8,
                        AW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                        AW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                        $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)),
                        $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            end
            eval();
            tick();
        end

        // Saturation: hold stall high for more cycles than the counter can count
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval(); tick();
        force dut.stall = 1'b1;
        repeat (65600) @(posedge clk);
        cnt += 65600;
        @(negedge clk);
        release dut.stall;
        model_reset();
        cnt = 65600;
        eval();
        chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
        tick();
        set_ins(1, 0, 0, 0, 0, 1, 7, 1, 0); eval(); tick();
        set_ins(1, 7, 1, 0, 0, 0, 0, 0, 0); eval(); tick();
        eval();
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
